// File: rtl/uart_tx_sched_if.sv
// Bus interface for uart_tx_sched: requester handshake plus transmitter control.
// master = scheduler side, slave = requesters/transmitter side.
interface uart_tx_sched_if #(
    parameter int N_REQ       = 4,
    parameter int PACKET_SIZE = 4
);
    logic [N_REQ-1:0]             req;
    logic [N_REQ*PACKET_SIZE-1:0] reqData;
    logic [N_REQ-1:0]             grant;
    logic [N_REQ-1:0]             ack;
    logic                         sendSig;
    logic                         txStart;
    logic [PACKET_SIZE-1:0]       txData;
    logic                         txBusy;
    logic                         err;

    modport master (
        input  req, reqData, txBusy,
        output grant, ack, sendSig, txStart, txData, err
    );

    modport slave (
        output req, reqData, txBusy,
        input  grant, ack, sendSig, txStart, txData, err
    );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among N_REQ
// requesters. Each transaction: grant, latch packet, announce on sendSig, start
// the transmitter, wait for it to finish, idle guard, then ack the requester.
// Optional watchdog on the BUSY phase: define UART_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
    parameter int PACKET_SIZE    = 4,
    parameter int N_REQ          = 4,
    parameter int CYCLE_DIV      = 100,
    parameter int ANNOUNCE_TICKS = 1,
    parameter int GAP_TICKS      = 0,
    parameter int GUARD_TICKS    = 1,
    parameter int TIMEOUT_TICKS  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_sched_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ANNOUNCE,
        ST_GAP,
        ST_BUSY,
        ST_GUARD
    } state_t;

    localparam int CNT_W     = (CYCLE_DIV > 1) ? $clog2(CYCLE_DIV) : 1;
    localparam int MAX_AG    = (ANNOUNCE_TICKS > GAP_TICKS) ? ANNOUNCE_TICKS : GAP_TICKS;
    localparam int MAX_GT    = (GUARD_TICKS > TIMEOUT_TICKS) ? GUARD_TICKS : TIMEOUT_TICKS;
    localparam int MAX_TICKS = (MAX_AG > MAX_GT) ? MAX_AG : MAX_GT;
    localparam int TICK_W    = $clog2(MAX_TICKS + 1);
    localparam int IDX_W     = $clog2(N_REQ);

    localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(CYCLE_DIV - 1);
    localparam logic [TICK_W-1:0] ANN_LAST   = TICK_W'(ANNOUNCE_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LAST   = TICK_W'(GAP_TICKS - 1);
    localparam logic [TICK_W-1:0] GUARD_LAST = TICK_W'(GUARD_TICKS - 1);
`ifdef UART_SCHED_TIMEOUT_EN
    localparam logic [TICK_W-1:0] TMO_LAST   = TICK_W'(TIMEOUT_TICKS - 1);
`endif

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        div_q, div_d;
    logic [TICK_W-1:0]       ticks_q, ticks_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [N_REQ-1:0]        grant_q, grant_d;
    logic [N_REQ-1:0]        ack_q, ack_d;
    logic                    send_q, send_d;
    logic                    start_q, start_d;
    logic [PACKET_SIZE-1:0]  data_q, data_d;
    logic                    err_q, err_d;
    logic                    seen_q, seen_d;

    logic                    tick;
    logic                    pick_valid;
    logic [IDX_W-1:0]        pick_idx;
    int                      cand;

    // Round-robin search: first pending request strictly after the last grant, with wrap.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(last_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Transaction FSM: next state, registered outputs, and per-phase divider/tick count.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        ack_d   = '0;
        send_d  = send_q;
        start_d = 1'b0;
        data_d  = data_q;
        err_d   = 1'b0;
        seen_d  = seen_q;
        div_d   = div_q;
        ticks_d = ticks_q;
        tick    = (div_q == DIV_LAST);

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    data_d  = bus.reqData[int'(pick_idx)*PACKET_SIZE +: PACKET_SIZE];
                    last_d  = pick_idx;
                    send_d  = 1'b1;
                    state_d = ST_ANNOUNCE;
                end
            end
            ST_ANNOUNCE: begin
                if (tick && ticks_q == ANN_LAST) begin
                    send_d = 1'b0;
                    if (GAP_TICKS == 0) begin
                        start_d = 1'b1;
                        seen_d  = 1'b0;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (tick && ticks_q == GAP_LAST) begin
                    start_d = 1'b1;
                    seen_d  = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // txBusy during the txStart cycle still reflects the previous frame, so it is ignored.
                if (!start_q && bus.txBusy) begin
                    seen_d = 1'b1;
                end
                if (seen_q && !bus.txBusy) begin
                    if (GUARD_TICKS == 0) begin
                        ack_d   = grant_q;
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GUARD;
                    end
                end
`ifdef UART_SCHED_TIMEOUT_EN
                else if (tick && ticks_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_GUARD: begin
                if (tick && ticks_q == GUARD_LAST) begin
                    ack_d   = grant_q;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                send_d  = 1'b0;
            end
        endcase

        if (state_d != state_q) begin
            div_d   = '0;
            ticks_d = '0;
        end else if (tick) begin
            div_d   = '0;
            ticks_d = ticks_q + 1'b1;
        end else begin
            div_d   = div_q + 1'b1;
        end
    end

    // State and output registers; reset aborts any transaction immediately without ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            ticks_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            grant_q <= '0;
            ack_q   <= '0;
            send_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ticks_q <= ticks_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            send_q  <= send_d;
            start_q <= start_d;
            data_q  <= data_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.ack     = ack_q;
    assign bus.sendSig = send_q;
    assign bus.txStart = start_q;
    assign bus.txData  = data_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: a default-parameter instance and a GAP_TICKS=2 /
// TIMEOUT_TICKS=4 instance; only the selected instance receives stimulus.
// Expected grants come from a round-robin model pushed into a scoreboard queue.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_drv;
    logic [15:0] data_drv;
    logic        busy_drv;
    logic        use_gap;

    // 10 ns system clock.
    always #5 clk = ~clk;

    uart_tx_sched_if #(.N_REQ(4), .PACKET_SIZE(4)) d_if ();
    uart_tx_sched_if #(.N_REQ(4), .PACKET_SIZE(4)) g_if ();

    assign d_if.req     = use_gap ? 4'b0 : req_drv;
    assign d_if.reqData = data_drv;
    assign d_if.txBusy  = use_gap ? 1'b0 : busy_drv;
    assign g_if.req     = use_gap ? req_drv : 4'b0;
    assign g_if.reqData = data_drv;
    assign g_if.txBusy  = use_gap ? busy_drv : 1'b0;

    uart_tx_sched #(
        .PACKET_SIZE(4), .N_REQ(4), .CYCLE_DIV(100), .ANNOUNCE_TICKS(1),
        .GAP_TICKS(0), .GUARD_TICKS(1), .TIMEOUT_TICKS(64)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(d_if)
    );

    uart_tx_sched #(
        .PACKET_SIZE(4), .N_REQ(4), .CYCLE_DIV(100), .ANNOUNCE_TICKS(1),
        .GAP_TICKS(2), .GUARD_TICKS(1), .TIMEOUT_TICKS(4)
    ) u_gap (
        .clk(clk), .rst_n(rst_n), .bus(g_if)
    );

    wire [3:0] cur_grant = use_gap ? g_if.grant   : d_if.grant;
    wire [3:0] cur_ack   = use_gap ? g_if.ack     : d_if.ack;
    wire       cur_send  = use_gap ? g_if.sendSig : d_if.sendSig;
    wire       cur_start = use_gap ? g_if.txStart : d_if.txStart;
    wire [3:0] cur_data  = use_gap ? g_if.txData  : d_if.txData;
    wire       cur_err   = use_gap ? g_if.err     : d_if.err;

    typedef struct packed {
        logic [3:0] grant;
        logic [3:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_last = 3;

    function automatic int model_pick(input logic [3:0] r, input int last);
        for (int i = 1; i <= 4; i++) begin
            if (r[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    task automatic push_expect(input logic [3:0] r, input logic [15:0] d);
        exp_t e;
        int   w;
        w = model_pick(r, model_last);
        model_last = w;
        e.grant = 4'(1 << w);
        e.data  = d[w*4 +: 4];
        exp_q.push_back(e);
    endtask

    // Waits on negedges for an event; cyc = negedges consumed, ok = event seen in budget.
    task automatic wait_ev(input int sel, input int maxc, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < maxc && !ok) begin
            @(negedge clk);
            cyc++;
            case (sel)
                0: ok = |cur_grant;
                1: ok = cur_start;
                2: ok = |cur_ack;
                3: ok = !cur_send;
                default: ok = cur_err;
            endcase
        end
    endtask

    task automatic do_reset(input logic gap);
        use_gap  = gap;
        rst_n    = 1'b0;
        req_drv  = 4'b0;
        busy_drv = 1'b0;
        data_drv = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_last = 3;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset;
        use_gap  = 1'b0;
        rst_n    = 1'b0;
        req_drv  = 4'b1111;
        data_drv = 16'hFFFF;
        busy_drv = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cur_grant, cur_ack} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_grant_ack: got %b_%b expected 0000_0000", cur_grant, cur_ack);
        end
        checks++;
        if ({cur_send, cur_start, cur_err} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_send_start_err: got %b expected 000", {cur_send, cur_start, cur_err});
        end
        checks++;
        if (cur_data !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_txdata: got %h expected 0", cur_data);
        end
    endtask

    task automatic test_single_txn;
        int   cyc;
        bit   ok;
        exp_t e;
        do_reset(1'b0);
        data_drv = 16'h0006;
        req_drv  = 4'b0001;
        push_expect(req_drv, data_drv);
        wait_ev(0, 10, cyc, ok);
        checks++;
        if (!ok || cyc !== 1) begin
            errors++;
            $display("[TB] FAIL single_grant_latency: got %0d cycles expected 1", cyc);
        end
        e = exp_q.pop_front();
        checks++;
        if (cur_grant !== e.grant || cur_data !== e.data || cur_send !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_grant: got grant=%b data=%h send=%b expected grant=%b data=%h send=1",
                     cur_grant, cur_data, cur_send, e.grant, e.data);
        end
        req_drv  = 4'b0;
        data_drv = 16'hFFFF;
        wait_ev(3, 300, cyc, ok);
        checks++;
        if (!ok || cyc !== 100) begin
            errors++;
            $display("[TB] FAIL announce_len: got %0d cycles expected 100", cyc);
        end
        checks++;
        if (cur_start !== 1'b1 || cur_data !== 4'h6) begin
            errors++;
            $display("[TB] FAIL start_with_fall: got start=%b data=%h expected start=1 data=6", cur_start, cur_data);
        end
        busy_drv = 1'b1;
        @(negedge clk);
        checks++;
        if (cur_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_pulse: got %b expected 0", cur_start);
        end
        repeat (799) @(negedge clk);
        busy_drv = 1'b0;
        wait_ev(2, 300, cyc, ok);
        checks++;
        if (!ok || cyc !== 101 || cur_ack !== 4'b0001 || cur_grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL guard_ack: got cyc=%0d ack=%b grant=%b expected cyc=101 ack=0001 grant=0000",
                     cyc, cur_ack, cur_grant);
        end
        @(negedge clk);
        checks++;
        if (cur_ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL ack_pulse: got %b expected 0000", cur_ack);
        end
    endtask

    task automatic test_round_robin;
        int         cyc;
        bit         ok;
        exp_t       e;
        do_reset(1'b0);
        data_drv = 16'hDCBA;
        req_drv  = 4'b1111;
        for (int k = 0; k < 5; k++) push_expect(req_drv, data_drv);
        for (int t = 0; t < 5; t++) begin
            wait_ev(0, 10, cyc, ok);
            checks++;
            if (!ok || cyc !== 1) begin
                errors++;
                $display("[TB] FAIL rr_grant_after_ack[%0d]: got %0d cycles expected 1", t, cyc);
            end
            e = exp_q.pop_front();
            checks++;
            if (cur_grant !== e.grant || cur_data !== e.data) begin
                errors++;
                $display("[TB] FAIL rr_grant[%0d]: got grant=%b data=%h expected grant=%b data=%h",
                         t, cur_grant, cur_data, e.grant, e.data);
            end
            wait_ev(1, 500, cyc, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("[TB] FAIL rr_start[%0d]: got no txStart expected pulse", t);
            end
            busy_drv = 1'b1;
            repeat (20) @(negedge clk);
            busy_drv = 1'b0;
            wait_ev(2, 500, cyc, ok);
            checks++;
            if (!ok || cur_ack !== e.grant) begin
                errors++;
                $display("[TB] FAIL rr_ack[%0d]: got %b expected %b", t, cur_ack, e.grant);
            end
            if (t == 4) req_drv = 4'b0;
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL rr_scoreboard_empty: got %0d left expected 0", exp_q.size());
        end
    endtask

    task automatic test_gap;
        int   cyc;
        bit   ok;
        exp_t e;
        do_reset(1'b1);
        data_drv = 16'h0900;
        req_drv  = 4'b0100;
        push_expect(req_drv, data_drv);
        wait_ev(0, 10, cyc, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc !== 1 || cur_grant !== e.grant || cur_data !== e.data) begin
            errors++;
            $display("[TB] FAIL gap_grant: got cyc=%0d grant=%b data=%h expected cyc=1 grant=%b data=%h",
                     cyc, cur_grant, cur_data, e.grant, e.data);
        end
        req_drv = 4'b0;
        wait_ev(3, 300, cyc, ok);
        checks++;
        if (!ok || cyc !== 100 || cur_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gap_announce: got cyc=%0d start=%b expected cyc=100 start=0", cyc, cur_start);
        end
        wait_ev(1, 500, cyc, ok);
        checks++;
        if (!ok || cyc !== 200) begin
            errors++;
            $display("[TB] FAIL gap_len: got %0d cycles expected 200", cyc);
        end
        busy_drv = 1'b1;
        repeat (30) @(negedge clk);
        busy_drv = 1'b0;
        wait_ev(2, 300, cyc, ok);
        checks++;
        if (!ok || cyc !== 101 || cur_ack !== 4'b0100 || cur_data !== 4'h9) begin
            errors++;
            $display("[TB] FAIL dropped_req_ack: got cyc=%0d ack=%b data=%h expected cyc=101 ack=0100 data=9",
                     cyc, cur_ack, cur_data);
        end
    endtask

    task automatic test_reset_mid;
        int   cyc;
        bit   ok;
        exp_t e;
        do_reset(1'b0);
        data_drv = 16'h0021;
        req_drv  = 4'b0001;
        push_expect(req_drv, data_drv);
        wait_ev(0, 10, cyc, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cur_grant !== e.grant) begin
            errors++;
            $display("[TB] FAIL mid_first_grant: got %b expected %b", cur_grant, e.grant);
        end
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (cur_send !== 1'b0 || cur_grant !== 4'b0000 || cur_ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL async_reset: got send=%b grant=%b ack=%b expected 0 0000 0000",
                     cur_send, cur_grant, cur_ack);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        model_last = 3;
        req_drv    = 4'b0011;
        push_expect(req_drv, data_drv);
        wait_ev(0, 10, cyc, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc !== 1 || cur_grant !== e.grant || cur_data !== e.data) begin
            errors++;
            $display("[TB] FAIL post_reset_grant: got cyc=%0d grant=%b data=%h expected cyc=1 grant=%b data=%h",
                     cyc, cur_grant, cur_data, e.grant, e.data);
        end
        req_drv = 4'b0;
    endtask

`ifdef UART_SCHED_TIMEOUT_EN
    task automatic test_timeout;
        int   cyc;
        bit   ok;
        exp_t e;
        do_reset(1'b1);
        data_drv = 16'h0053;
        req_drv  = 4'b0001;
        push_expect(req_drv, data_drv);
        wait_ev(0, 10, cyc, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cur_grant !== e.grant) begin
            errors++;
            $display("[TB] FAIL tmo_grant: got %b expected %b", cur_grant, e.grant);
        end
        req_drv = 4'b0;
        wait_ev(1, 500, cyc, ok);
        busy_drv = 1'b1;
        wait_ev(4, 1000, cyc, ok);
        checks++;
        if (!ok || cyc !== 400 || cur_ack !== 4'b0000 || cur_grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL timeout_err: got cyc=%0d ack=%b grant=%b expected cyc=400 ack=0000 grant=0000",
                     cyc, cur_ack, cur_grant);
        end
        busy_drv = 1'b0;
        req_drv  = 4'b0011;
        push_expect(req_drv, data_drv);
        wait_ev(0, 10, cyc, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc !== 1 || cur_grant !== e.grant || cur_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tmo_next_grant: got cyc=%0d grant=%b err=%b expected cyc=1 grant=%b err=0",
                     cyc, cur_grant, cur_err, e.grant);
        end
        req_drv = 4'b0;
    endtask
`else
    task automatic test_no_watchdog;
        int   cyc;
        bit   ok;
        int   err_cnt;
        exp_t e;
        do_reset(1'b1);
        data_drv = 16'h0005;
        req_drv  = 4'b0001;
        push_expect(req_drv, data_drv);
        wait_ev(0, 10, cyc, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cur_grant !== e.grant || cur_data !== e.data) begin
            errors++;
            $display("[TB] FAIL nowd_grant: got grant=%b data=%h expected grant=%b data=%h",
                     cur_grant, cur_data, e.grant, e.data);
        end
        req_drv = 4'b0;
        wait_ev(1, 500, cyc, ok);
        busy_drv = 1'b1;
        err_cnt  = 0;
        repeat (600) begin
            @(negedge clk);
            if (cur_err) err_cnt++;
        end
        checks++;
        if (err_cnt !== 0 || cur_grant !== 4'b0001 || cur_ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL busy_hold: got err_cycles=%0d grant=%b ack=%b expected 0 0001 0000",
                     err_cnt, cur_grant, cur_ack);
        end
        busy_drv = 1'b0;
        wait_ev(2, 300, cyc, ok);
        checks++;
        if (!ok || cyc !== 101 || cur_ack !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL nowd_ack: got cyc=%0d ack=%b expected cyc=101 ack=0001", cyc, cur_ack);
        end
    endtask
`endif

    // Runs every scenario in order and prints the summary.
    initial begin
        test_reset();
        test_single_txn();
        test_round_robin();
        test_gap();
        test_reset_mid();
`ifdef UART_SCHED_TIMEOUT_EN
        test_timeout();
`else
        test_no_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so a stuck run still terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got no completion expected finish before 2 ms");
        $fatal(1, "[TB] simulation time bound exceeded");
    end

endmodule
